// File: rtl/fft_frame_sched.sv
// fft_frame_sched: sequences one FFT frame (core reset, start pulse, magnitude unload) and reports
// the banded peak, with timeout and frame-length error flags.
module fft_frame_sched #(
    parameter int N_POINTS  = 1024,
    parameter int AW        = 10,
    parameter int RST_CYC   = 4,
    parameter int START_CYC = 2,
    parameter int PK_LO     = 1,
    parameter int PK_HI     = 511,
    parameter int TMO       = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic          cont_mode,
    input  logic          abort,
    output logic          fft_rst,
    output logic          fft_start,
    input  logic [15:0]   amp,
    input  logic          amp_sop,
    input  logic          amp_eop,
    input  logic          amp_valid,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   peak_amp,
    output logic [AW-1:0] peak_bin,
    output logic [15:0]   frame_cnt,
    output logic          err_tmo,
    output logic          err_len
);
    localparam int CMAX = RST_CYC > START_CYC ? RST_CYC : START_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TMO + 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO - 1);
    localparam logic [AW-1:0] BIN_LAST   = AW'(N_POINTS - 1);
    localparam logic [AW-1:0] LO         = AW'(PK_LO);
    localparam logic [AW-1:0] HI         = AW'(PK_HI);

    typedef enum logic [2:0] {IDLE, CRST, START, WSOP, UNLD, DONE} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [AW-1:0] bin, bin_nx, cur;
    logic [15:0]   run_max, run_max_nx, base;
    logic [AW-1:0] run_bin, run_bin_nx;
    logic          ovf, upd, beat, good, set_tmo, set_len;

    // cur is the bin of the beat on the bus; ovf marks beats past the last bin, which are dropped
    always_comb begin
        ovf        = !amp_sop && bin == BIN_LAST;
        cur        = amp_sop ? '0 : bin + 1'b1;
        base       = amp_sop ? '0 : run_max;
        upd        = !ovf && cur >= LO && cur <= HI && amp > base;
        beat       = amp_valid && (amp_sop || state == UNLD);
        good       = !ovf && cur == BIN_LAST;
        nxt        = state;
        cnt_nx     = cnt;
        tmo_nx     = tmo;
        bin_nx     = bin;
        run_max_nx = run_max;
        run_bin_nx = run_bin;
        set_tmo    = 1'b0;
        set_len    = 1'b0;
        case (state)
            IDLE: if (trig) begin
                nxt    = CRST;
                cnt_nx = '0;
            end
            CRST: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == RST_LAST) begin
                    nxt    = START;
                    cnt_nx = '0;
                end
            end
            START: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == START_LAST) begin
                    nxt    = WSOP;
                    tmo_nx = '0;
                end
            end
            WSOP, UNLD: if (beat) begin
                tmo_nx     = '0;
                bin_nx     = ovf ? bin : cur;
                run_max_nx = upd ? amp : base;
                run_bin_nx = upd ? cur : (amp_sop ? LO : run_bin);
                nxt        = !amp_eop ? UNLD : good ? DONE : IDLE;
                set_len    = amp_eop && !good;
            end else if (tmo == TMO_LAST) begin
                nxt     = IDLE;
                set_tmo = 1'b1;
            end else begin
                tmo_nx = tmo + 1'b1;
            end
            DONE: begin
                nxt    = cont_mode ? START : IDLE;
                cnt_nx = '0;
            end
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            nxt     = IDLE;
            set_tmo = 1'b0;
            set_len = 1'b0;
        end
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            bin        <= '0;
            run_max    <= '0;
            run_bin    <= '0;
            fft_rst    <= 1'b0;
            fft_start  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            peak_amp   <= '0;
            peak_bin   <= '0;
            frame_cnt  <= '0;
            err_tmo    <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nx;
            tmo        <= tmo_nx;
            bin        <= bin_nx;
            run_max    <= run_max_nx;
            run_bin    <= run_bin_nx;
            fft_rst    <= nxt == CRST;
            fft_start  <= nxt == START;
            busy       <= nxt != IDLE;
            frame_done <= nxt == DONE;
            if (nxt == DONE) begin
                peak_amp  <= run_max_nx;
                peak_bin  <= run_bin_nx;
                frame_cnt <= frame_cnt + 1'b1;
            end
            err_tmo    <= (state == IDLE && trig) ? 1'b0 : err_tmo | set_tmo;
            err_len    <= (state == IDLE && trig) ? 1'b0 : err_len | set_len;
        end
    end
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: randomized frame streams checked against a list-based peak/length model.
module tb_fft_frame_sched;
    localparam int N = 1024, AW = 10, RST_CYC = 4, START_CYC = 2, PK_LO = 1, PK_HI = 511, TMO = 65535;

    logic          clk = 0, rst = 0, trig = 0, cont_mode = 0, abort = 0;
    logic [15:0]   amp = 0;
    logic          amp_sop = 0, amp_eop = 0, amp_valid = 0;
    logic          fft_rst, fft_start, busy, frame_done, err_tmo, err_len;
    logic [15:0]   peak_amp, frame_cnt;
    logic [AW-1:0] peak_bin;

    fft_frame_sched #(.N_POINTS(N), .AW(AW), .RST_CYC(RST_CYC), .START_CYC(START_CYC),
                      .PK_LO(PK_LO), .PK_HI(PK_HI), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .trig(trig), .cont_mode(cont_mode), .abort(abort),
        .fft_rst(fft_rst), .fft_start(fft_start), .amp(amp), .amp_sop(amp_sop),
        .amp_eop(amp_eop), .amp_valid(amp_valid), .busy(busy), .frame_done(frame_done),
        .peak_amp(peak_amp), .peak_bin(peak_bin), .frame_cnt(frame_cnt),
        .err_tmo(err_tmo), .err_len(err_len));

    always #5 clk = ~clk;

    int            checks = 0, errors = 0, done_cnt = 0, rst_cyc = 0, exp_done = 0;
    logic [15:0]   exp_amp = 0, exp_cnt = 0;
    logic [AW-1:0] exp_bin = 0;
    logic [15:0]   fr [0:N+63];
    int            fr_len;

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (fft_rst) rst_cyc++;
    end

    task automatic drive_idle;
        amp_valid = 0; amp_sop = 0; amp_eop = 0; amp = 16'($urandom);
    endtask

    task automatic fill(input int len, input int mode);
        fr_len = len;
        for (int i = 0; i < len; i++) fr[i] = mode == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
    endtask

    // reference: frame is good iff exactly N beats; peak is the first strict max over the band
    task automatic model_peak(output logic [15:0] a, output logic [AW-1:0] b);
        a = 0;
        b = AW'(PK_LO);
        for (int i = PK_LO; i <= PK_HI && i < fr_len; i++)
            if (fr[i] > a) begin a = fr[i]; b = AW'(i); end
    endtask

    task automatic stream(input int from, input int to);
        for (int i = from; i < to; i++) begin
            if ($urandom_range(0, 99) < 12) begin @(negedge clk); drive_idle(); end
            @(negedge clk);
            amp_valid = 1; amp_sop = (i == 0); amp_eop = (i == fr_len - 1); amp = fr[i];
        end
    endtask

    task automatic pulse_trig;
        @(negedge clk); trig = 1;
        @(negedge clk); trig = 0;
    endtask

    task automatic wait_wsop;
        bit seen = 0;
        int n;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (fft_start) seen = 1;
            else if (seen) break;
        end
        checks++;
        if (!seen || fft_start !== 1'b0) begin
            errors++;
            $display("FAIL wait_wsop: start_seen=%0d fft_start=%b after %0d cycles, required start pulse then low", seen, fft_start, n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({fft_rst, fft_start, busy, frame_done, err_tmo, err_len} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000", {fft_rst, fft_start, busy, frame_done, err_tmo, err_len});
        end
        checks++;
        if (peak_amp !== 0 || peak_bin !== 0 || frame_cnt !== 0) begin
            errors++;
            $display("FAIL reset_values: amp=%h bin=%0d cnt=%0d, required all 0", peak_amp, peak_bin, frame_cnt);
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_timing_first_frame;
        for (int i = 0; i < N; i++) fr[i] = 16'(i & 255);
        fr[300] = 16'h7FFF;
        fr_len = N;
        @(negedge clk); trig = 1;
        for (int n = 0; n < RST_CYC + START_CYC + 2; n++) begin
            @(negedge clk); trig = 0;
            checks++;
            if (fft_rst !== (n < RST_CYC) || fft_start !== (n >= RST_CYC && n < RST_CYC + START_CYC) || busy !== 1'b1) begin
                errors++;
                $display("FAIL timing[%0d]: fft_rst=%b fft_start=%b busy=%b, required %b %b 1", n, fft_rst, fft_start, busy,
                         n < RST_CYC, n >= RST_CYC && n < RST_CYC + START_CYC);
            end
        end
        stream(0, fr_len);
        @(negedge clk); drive_idle();
        model_peak(exp_amp, exp_bin); exp_cnt++; exp_done++;
        checks++;
        if (frame_done !== 1 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL first_frame: done=%b amp=%h bin=%0d cnt=%0d, required 1 %h %0d %0d", frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (busy !== 0 || frame_done !== 0) begin
            errors++;
            $display("FAIL first_frame_idle: busy=%b done=%b, required 0 0", busy, frame_done);
        end
    endtask

    task automatic test_dc_skip;
        fr_len = N;
        for (int i = 0; i < N; i++) fr[i] = 0;
        fr[0] = 16'hFFFF; fr[100] = 16'h1234; fr[200] = 16'h1234;
        pulse_trig(); wait_wsop();
        stream(0, fr_len);
        @(negedge clk); drive_idle();
        model_peak(exp_amp, exp_bin); exp_cnt++; exp_done++;
        checks++;
        if (frame_done !== 1 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL dc_skip: done=%b amp=%h bin=%0d cnt=%0d, required 1 %h %0d %0d", frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 2; f++) begin
            fill(N, f);
            pulse_trig(); wait_wsop();
            stream(0, fr_len);
            @(negedge clk); drive_idle();
            model_peak(exp_amp, exp_bin); exp_cnt++; exp_done++;
            checks++;
            if (frame_done !== 1 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL random_frame[%0d]: done=%b amp=%h bin=%0d cnt=%0d, required 1 %h %0d %0d", f, frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
            end
        end
    endtask

    task automatic test_len_err;
        fill(1001, 1);
        pulse_trig(); wait_wsop();
        stream(0, fr_len);
        @(negedge clk); drive_idle();
        checks++;
        if (err_len !== 1 || err_tmo !== 0 || busy !== 0 || frame_done !== 0 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL len_err: err_len=%b err_tmo=%b busy=%b done=%b amp=%h bin=%0d cnt=%0d, required 1 0 0 0 %h %0d %0d",
                     err_len, err_tmo, busy, frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done) begin
            errors++;
            $display("FAIL len_err_pulses: %0d done pulses, required %0d", done_cnt, exp_done);
        end
        pulse_trig();
        checks++;
        if (err_len !== 0 || busy !== 1 || fft_rst !== 1) begin
            errors++;
            $display("FAIL len_err_clear: err_len=%b busy=%b fft_rst=%b, required 0 1 1", err_len, busy, fft_rst);
        end
        abort = 1; @(negedge clk); abort = 0;
        checks++;
        if (busy !== 0 || fft_rst !== 0) begin
            errors++;
            $display("FAIL abort_crst: busy=%b fft_rst=%b, required 0 0", busy, fft_rst);
        end
    endtask

    task automatic test_back_to_back;
        int r0;
        cont_mode = 1;
        pulse_trig(); wait_wsop();
        r0 = rst_cyc;
        for (int f = 0; f < 3; f++) begin
            fill(N, f & 1);
            if (f == 2) cont_mode = 0;
            stream(0, fr_len);
            @(negedge clk); drive_idle();
            model_peak(exp_amp, exp_bin); exp_cnt++; exp_done++;
            checks++;
            if (frame_done !== 1 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL cont_frame[%0d]: done=%b amp=%h bin=%0d cnt=%0d, required 1 %h %0d %0d", f, frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
            end
            if (f < 2) wait_wsop();
        end
        @(negedge clk);
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL cont_stop: busy=%b, required 0", busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done || rst_cyc !== r0) begin
            errors++;
            $display("FAIL cont_counts: done pulses=%0d fft_rst cycles=%0d, required %0d %0d", done_cnt, rst_cyc, exp_done, r0);
        end
    endtask

    task automatic test_abort;
        fill(N, 1);
        pulse_trig(); wait_wsop();
        stream(0, 400);
        @(negedge clk); drive_idle(); abort = 1;
        @(negedge clk); abort = 0;
        checks++;
        if (busy !== 0 || fft_rst !== 0 || fft_start !== 0 || err_tmo !== 0 || err_len !== 0 ||
            peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL abort: busy=%b rst=%b start=%b tmo=%b len=%b amp=%h bin=%0d cnt=%0d, required 0 0 0 0 0 %h %0d %0d",
                     busy, fft_rst, fft_start, err_tmo, err_len, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
        end
        stream(400, fr_len);
        @(negedge clk); drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done || busy !== 0 || err_len !== 0 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL abort_tail: pulses=%0d busy=%b err_len=%b cnt=%0d, required %0d 0 0 %0d", done_cnt, busy, err_len, frame_cnt, exp_done, exp_cnt);
        end
    endtask

    task automatic test_async_reset;
        fill(N, 1);
        pulse_trig(); wait_wsop();
        stream(0, 300);
        @(negedge clk); #2 rst = 0;
        #1;
        exp_amp = 0; exp_bin = 0; exp_cnt = 0;
        checks++;
        if ({fft_rst, fft_start, busy, frame_done, err_tmo, err_len} !== 6'b0 || peak_amp !== 0 || peak_bin !== 0 || frame_cnt !== 0) begin
            errors++;
            $display("FAIL async_reset: flags=%b amp=%h bin=%0d cnt=%0d, required all 0", {fft_rst, fft_start, busy, frame_done, err_tmo, err_len}, peak_amp, peak_bin, frame_cnt);
        end
        @(negedge clk); #2 rst = 1;
        stream(300, fr_len);
        @(negedge clk); drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done || busy !== 0 || err_len !== 0 || frame_cnt !== 0) begin
            errors++;
            $display("FAIL async_tail: pulses=%0d busy=%b err_len=%b cnt=%0d, required %0d 0 0 0", done_cnt, busy, err_len, frame_cnt, exp_done);
        end
        fill(N, 0);
        pulse_trig(); wait_wsop();
        stream(0, fr_len);
        @(negedge clk); drive_idle();
        model_peak(exp_amp, exp_bin); exp_cnt++; exp_done++;
        checks++;
        if (frame_done !== 1 || peak_amp !== exp_amp || peak_bin !== exp_bin || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL post_reset_frame: done=%b amp=%h bin=%0d cnt=%0d, required 1 %h %0d %0d", frame_done, peak_amp, peak_bin, frame_cnt, exp_amp, exp_bin, exp_cnt);
        end
    endtask

    task automatic test_timeout;
        pulse_trig(); wait_wsop();
        for (int n = 1; n < TMO; n++) begin
            @(negedge clk);
            amp_valid = 1'($urandom_range(0, 1)); amp_sop = 0; amp = 16'($urandom);
        end
        checks++;
        if (err_tmo !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL tmo_early: err_tmo=%b busy=%b, required 0 1", err_tmo, busy);
        end
        @(negedge clk); drive_idle();
        checks++;
        if (err_tmo !== 1 || busy !== 0 || fft_start !== 0 || fft_rst !== 0 || err_len !== 0) begin
            errors++;
            $display("FAIL tmo_hit: err_tmo=%b busy=%b start=%b rst=%b len=%b, required 1 0 0 0 0", err_tmo, busy, fft_start, fft_rst, err_len);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL tmo_no_done: pulses=%0d cnt=%0d, required %0d %0d", done_cnt, frame_cnt, exp_done, exp_cnt);
        end
        pulse_trig();
        checks++;
        if (err_tmo !== 0 || busy !== 1 || fft_rst !== 1) begin
            errors++;
            $display("FAIL tmo_clear: err_tmo=%b busy=%b fft_rst=%b, required 0 1 1", err_tmo, busy, fft_rst);
        end
        abort = 1; @(negedge clk); abort = 0;
    endtask

    initial begin
        test_reset();
        test_timing_first_frame();
        test_dc_skip();
        test_random_frames();
        test_len_err();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
